// File: rtl/transmissor_jogada_serial.sv
// UART (8N1, LSB first) transmitter for committed ultimate tic-tac-toe moves.
// Each move goes out as a 4-byte ASCII frame: player, macro cell, micro cell, '\n'.
module transmissor_jogada_serial #(
  parameter int CICLOS_BIT   = 434,
  parameter int LARGURA_CONT = 9
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       envia,
  input  logic [1:0] jogador,
  input  logic [8:0] macro,
  input  logic [8:0] micro,
  output logic       saida_serial,
  output logic       ocupado,
  output logic       pronto,
  output logic       descartado,
  output logic       erro_codigo,
  output logic [3:0] db_estado
);

  typedef enum logic [3:0] {
    INICIAL = 4'd0,
    CARREGA = 4'd1,
    START   = 4'd2,
    DADOS   = 4'd3,
    STOP    = 4'd4,
    PROX    = 4'd5,
    FIM     = 4'd6
  } estado_t;

  localparam logic [LARGURA_CONT-1:0] CONT_MAX =
    LARGURA_CONT'(CICLOS_BIT - 1);

  estado_t estado_q, estado_d;
  logic [LARGURA_CONT-1:0] cont_q, cont_d;
  logic [2:0] bit_q, bit_d;
  logic [1:0] byte_q, byte_d;
  logic [1:0] jog_q, jog_d;
  logic [8:0] mac_q, mac_d;
  logic [8:0] mic_q, mic_d;
  logic [7:0] b0_q, b0_d;
  logic [7:0] b1_q, b1_d;
  logic [7:0] b2_q, b2_d;
  logic erro_q, erro_d;
  logic desc_q, desc_d;

  logic [8:0] cod_mac;
  logic [8:0] cod_mic;
  logic [7:0] byte_atual;
  logic fim_bit;
  logic erro_jog;

  // Returns {error, ascii}: '1'..'9' for a one-hot cell, '?' otherwise.
  function automatic logic [8:0] cod_cel(input logic [8:0] c);
    logic [3:0] n;
    logic [7:0] a;
    n = 4'd0;
    a = 8'h3F;
    for (int i = 0; i < 9; i++) begin
      if (c[i]) begin
        n = n + 4'd1;
        a = 8'h31 + 8'(i);
      end
    end
    return (n == 4'd1) ? {1'b0, a} : {1'b1, 8'h3F};
  endfunction

  assign cod_mac = cod_cel(mac_q);
  assign cod_mic = cod_cel(mic_q);
  assign fim_bit = (cont_q == CONT_MAX);
  assign erro_jog = !((jog_q == 2'b01) || (jog_q == 2'b10));

  always_comb begin
    byte_atual = 8'h0A;
    unique case (byte_q)
      2'd0: byte_atual = b0_q;
      2'd1: byte_atual = b1_q;
      2'd2: byte_atual = b2_q;
      2'd3: byte_atual = 8'h0A;
      default: byte_atual = 8'h0A;
    endcase
  end

  always_comb begin
    estado_d = estado_q;
    cont_d   = cont_q;
    bit_d    = bit_q;
    byte_d   = byte_q;
    jog_d    = jog_q;
    mac_d    = mac_q;
    mic_d    = mic_q;
    b0_d     = b0_q;
    b1_d     = b1_q;
    b2_d     = b2_q;
    erro_d   = erro_q;
    desc_d   = envia && (estado_q != INICIAL);
    unique case (estado_q)
      INICIAL: begin
        if (envia) begin
          jog_d    = jogador;
          mac_d    = macro;
          mic_d    = micro;
          estado_d = CARREGA;
        end
      end
      CARREGA: begin
        b0_d = (jog_q == 2'b01) ? 8'h58 :
               (jog_q == 2'b10) ? 8'h4F : 8'h2D;
        b1_d     = cod_mac[7:0];
        b2_d     = cod_mic[7:0];
        erro_d   = erro_jog | cod_mac[8] | cod_mic[8];
        byte_d   = 2'd0;
        cont_d   = '0;
        estado_d = START;
      end
      START: begin
        cont_d = cont_q + 1'b1;
        if (fim_bit) begin
          cont_d   = '0;
          bit_d    = 3'd0;
          estado_d = DADOS;
        end
      end
      DADOS: begin
        cont_d = cont_q + 1'b1;
        if (fim_bit) begin
          cont_d = '0;
          bit_d  = bit_q + 3'd1;
          if (bit_q == 3'd7) estado_d = STOP;
        end
      end
      STOP: begin
        cont_d = cont_q + 1'b1;
        if (fim_bit) begin
          cont_d   = '0;
          estado_d = (byte_q == 2'd3) ? FIM : PROX;
        end
      end
      PROX: begin
        byte_d   = byte_q + 2'd1;
        cont_d   = '0;
        estado_d = START;
      end
      FIM: begin
        cont_d   = '0;
        estado_d = INICIAL;
      end
      default: begin
        cont_d   = '0;
        estado_d = INICIAL;
      end
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      estado_q <= INICIAL;
      cont_q   <= '0;
      bit_q    <= '0;
      byte_q   <= '0;
      jog_q    <= '0;
      mac_q    <= '0;
      mic_q    <= '0;
      b0_q     <= '0;
      b1_q     <= '0;
      b2_q     <= '0;
      erro_q   <= 1'b0;
      desc_q   <= 1'b0;
    end else begin
      estado_q <= estado_d;
      cont_q   <= cont_d;
      bit_q    <= bit_d;
      byte_q   <= byte_d;
      jog_q    <= jog_d;
      mac_q    <= mac_d;
      mic_q    <= mic_d;
      b0_q     <= b0_d;
      b1_q     <= b1_d;
      b2_q     <= b2_d;
      erro_q   <= erro_d;
      desc_q   <= desc_d;
    end
  end

  // Outputs decode straight from flops, so reset reaches the line at once.
  always_comb begin
    saida_serial = 1'b1;
    unique case (estado_q)
      START:   saida_serial = 1'b0;
      DADOS:   saida_serial = byte_atual[bit_q];
      default: saida_serial = 1'b1;
    endcase
  end

  assign ocupado     = (estado_q != INICIAL);
  assign pronto      = (estado_q == FIM);
  assign descartado  = desc_q;
  assign erro_codigo = erro_q;
  assign db_estado   = estado_q;

endmodule
